// File: rtl/memory_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter in front of a single main-memory port.
// Round-robin on ties, optional ACK handshake with a cycle-count timeout.
module memory_arbiter #(
  parameter int unsigned DATAWIDTH_BUS  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 8,
  parameter bit          USE_ACK        = 1'b1
) (
  input  logic                     MEMORY_ARBITER_CLOCK_50,
  input  logic                     MEMORY_ARBITER_RESET_InHigh,
  input  logic                     FETCH_REQ,
  input  logic [DATAWIDTH_BUS-1:0] FETCH_ADDRESS,
  output logic [DATAWIDTH_BUS-1:0] FETCH_DATA_OutBUS,
  output logic                     FETCH_DONE,
  output logic                     FETCH_ERR,
  input  logic                     DATA_REQ,
  input  logic                     DATA_WE,
  input  logic [DATAWIDTH_BUS-1:0] DATA_ADDRESS,
  input  logic [DATAWIDTH_BUS-1:0] DATA_WDATA,
  output logic [DATAWIDTH_BUS-1:0] DATA_DATA_OutBUS,
  output logic                     DATA_DONE,
  output logic                     DATA_ERR,
  output logic                     MEM_RD,
  output logic                     MEM_WR,
  output logic [DATAWIDTH_BUS-1:0] MEM_ADDRESS,
  output logic [DATAWIDTH_BUS-1:0] MEM_WDATA,
  input  logic [DATAWIDTH_BUS-1:0] MEM_RDATA,
  input  logic                     MEM_ACK,
  output logic                     BUSY,
  output logic                     LAST_GRANT
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [3:0] CntLast = 4'(TIMEOUT_CYCLES - 1);

  state_e     state_q;
  logic       owner_q;  // 1 = data requester owns the current access
  logic       we_q;
  logic [3:0] cnt_q;
  logic       ack_eff;
  logic       grant_data;

  assign ack_eff = USE_ACK ? MEM_ACK : 1'b1;
  assign BUSY    = (state_q != StIdle);

  always_comb begin
    grant_data = DATA_REQ;
    if (FETCH_REQ && DATA_REQ) grant_data = ~LAST_GRANT;
  end

  always_ff @(posedge MEMORY_ARBITER_CLOCK_50) begin
    if (MEMORY_ARBITER_RESET_InHigh) begin
      state_q           <= StIdle;
      owner_q           <= 1'b0;
      we_q              <= 1'b0;
      cnt_q             <= '0;
      LAST_GRANT        <= 1'b1;
      MEM_RD            <= 1'b0;
      MEM_WR            <= 1'b0;
      MEM_ADDRESS       <= '0;
      MEM_WDATA         <= '0;
      FETCH_DONE        <= 1'b0;
      FETCH_ERR         <= 1'b0;
      DATA_DONE         <= 1'b0;
      DATA_ERR          <= 1'b0;
      FETCH_DATA_OutBUS <= '0;
      DATA_DATA_OutBUS  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (FETCH_REQ || DATA_REQ) begin
            state_q    <= StAccess;
            owner_q    <= grant_data;
            LAST_GRANT <= grant_data;
            cnt_q      <= '0;
            if (grant_data) begin
              MEM_ADDRESS <= DATA_ADDRESS;
              MEM_WDATA   <= DATA_WDATA;
              we_q        <= DATA_WE;
              MEM_RD      <= ~DATA_WE;
              MEM_WR      <= DATA_WE;
            end else begin
              MEM_ADDRESS <= FETCH_ADDRESS;
              we_q        <= 1'b0;
              MEM_RD      <= 1'b1;
              MEM_WR      <= 1'b0;
            end
          end
        end
        StAccess: begin
          // ACK beats the timeout when both land on the last allowed cycle
          if (ack_eff || (cnt_q == CntLast)) begin
            state_q <= StDone;
            MEM_RD  <= 1'b0;
            MEM_WR  <= 1'b0;
            if (owner_q) begin
              DATA_DONE <= 1'b1;
              DATA_ERR  <= ~ack_eff;
              if (!ack_eff)  DATA_DATA_OutBUS <= '0;
              else if (!we_q) DATA_DATA_OutBUS <= MEM_RDATA;
            end else begin
              FETCH_DONE <= 1'b1;
              FETCH_ERR  <= ~ack_eff;
              FETCH_DATA_OutBUS <= ack_eff ? MEM_RDATA : '0;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StDone: begin
          state_q    <= StIdle;
          FETCH_DONE <= 1'b0;
          FETCH_ERR  <= 1'b0;
          DATA_DONE  <= 1'b0;
          DATA_ERR   <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed-vector bench for memory_arbiter: one ACK-mode instance and one USE_ACK=0 instance
// sharing stimulus.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, data_req, data_we, mem_ack;
  logic [31:0] fetch_addr, data_addr, data_wdata, mem_rdata;

  logic [31:0] f_data, d_data, m_addr, m_wdata;
  logic        f_done, f_err, d_done, d_err, m_rd, m_wr, busy, last_grant;

  logic [31:0] f_data2, d_data2, m_addr2, m_wdata2;
  logic        f_done2, f_err2, d_done2, d_err2, m_rd2, m_wr2, busy2, last_grant2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.DATAWIDTH_BUS(32), .TIMEOUT_CYCLES(8), .USE_ACK(1'b1)) dut (
    .MEMORY_ARBITER_CLOCK_50(clk), .MEMORY_ARBITER_RESET_InHigh(rst),
    .FETCH_REQ(fetch_req), .FETCH_ADDRESS(fetch_addr), .FETCH_DATA_OutBUS(f_data),
    .FETCH_DONE(f_done), .FETCH_ERR(f_err),
    .DATA_REQ(data_req), .DATA_WE(data_we), .DATA_ADDRESS(data_addr), .DATA_WDATA(data_wdata),
    .DATA_DATA_OutBUS(d_data), .DATA_DONE(d_done), .DATA_ERR(d_err),
    .MEM_RD(m_rd), .MEM_WR(m_wr), .MEM_ADDRESS(m_addr), .MEM_WDATA(m_wdata),
    .MEM_RDATA(mem_rdata), .MEM_ACK(mem_ack), .BUSY(busy), .LAST_GRANT(last_grant)
  );

  memory_arbiter #(.DATAWIDTH_BUS(32), .TIMEOUT_CYCLES(8), .USE_ACK(1'b0)) dut_noack (
    .MEMORY_ARBITER_CLOCK_50(clk), .MEMORY_ARBITER_RESET_InHigh(rst),
    .FETCH_REQ(fetch_req), .FETCH_ADDRESS(fetch_addr), .FETCH_DATA_OutBUS(f_data2),
    .FETCH_DONE(f_done2), .FETCH_ERR(f_err2),
    .DATA_REQ(data_req), .DATA_WE(data_we), .DATA_ADDRESS(data_addr), .DATA_WDATA(data_wdata),
    .DATA_DATA_OutBUS(d_data2), .DATA_DONE(d_done2), .DATA_ERR(d_err2),
    .MEM_RD(m_rd2), .MEM_WR(m_wr2), .MEM_ADDRESS(m_addr2), .MEM_WDATA(m_wdata2),
    .MEM_RDATA(mem_rdata), .MEM_ACK(mem_ack), .BUSY(busy2), .LAST_GRANT(last_grant2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int rd_cycles;
    rst = 1'b1; fetch_req = 0; data_req = 0; data_we = 0; mem_ack = 0;
    fetch_addr = '0; data_addr = '0; data_wdata = '0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_last_grant", last_grant, 1);
    check("rst_mem_rd", m_rd, 0);
    check("rst_mem_addr", m_addr, 0);
    check("rst_fetch_data", f_data, 0);
    check("rst_fetch_done", f_done, 0);

    // Single fetch read
    fetch_req = 1; fetch_addr = 32'h800; mem_rdata = 32'hC400_2000; mem_ack = 1;
    tick();
    check("f1_mem_rd", m_rd, 1);
    check("f1_mem_addr", m_addr, 32'h800);
    check("f1_busy", busy, 1);
    check("f1_last_grant", last_grant, 0);
    check("f1_done_early", f_done, 0);
    tick();
    check("f1_done", f_done, 1);
    check("f1_data", f_data, 32'hC400_2000);
    check("f1_err", f_err, 0);
    check("f1_rd_off", m_rd, 0);
    check("f1_ddone", d_done, 0);
    fetch_req = 0;
    tick();
    check("f1_idle", busy, 0);
    check("f1_done_fall", f_done, 0);

    // Tie after reset: fetch first, then data
    do_reset();
    fetch_req = 1; fetch_addr = 32'h800; data_req = 1; data_we = 0; data_addr = 32'h900;
    mem_rdata = 32'h1111_2222; mem_ack = 1;
    tick();
    check("tie_c1_addr", m_addr, 32'h800);
    check("tie_c1_lg", last_grant, 0);
    tick();
    check("tie_c2_fdone", f_done, 1);
    check("tie_c2_ddone", d_done, 0);
    fetch_req = 0;
    tick();
    check("tie_c3_rd", m_rd, 0);
    check("tie_c3_busy", busy, 0);
    mem_rdata = 32'h3333_4444;
    tick();
    check("tie_c4_rd", m_rd, 1);
    check("tie_c4_addr", m_addr, 32'h900);
    check("tie_c4_lg", last_grant, 1);
    tick();
    check("tie_c5_ddone", d_done, 1);
    check("tie_c5_ddata", d_data, 32'h3333_4444);
    check("tie_c5_fdata", f_data, 32'h1111_2222);
    check("tie_c5_fdone", f_done, 0);
    data_req = 0;
    tick();

    // Store
    data_req = 1; data_we = 1; data_addr = 32'h830; data_wdata = 32'hFFFF_FFFF;
    tick();
    check("st_wr", m_wr, 1);
    check("st_rd", m_rd, 0);
    check("st_addr", m_addr, 32'h830);
    check("st_wdata", m_wdata, 32'hFFFF_FFFF);
    tick();
    check("st_done", d_done, 1);
    check("st_ddata", d_data, 32'h3333_4444);
    check("st_wr_off", m_wr, 0);
    check("st_rd_off", m_rd, 0);
    data_req = 0; data_we = 0;
    tick();

    // Timeout with ACK stuck low
    mem_ack = 0; fetch_req = 1; fetch_addr = 32'h840; mem_rdata = 32'hDEAD_BEEF;
    rd_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_rd) rd_cycles++;
      if (f_done) break;
    end
    check("to_done", f_done, 1);
    check("to_rd_cycles", rd_cycles, 8);
    check("to_err", f_err, 1);
    check("to_data", f_data, 0);
    fetch_req = 0;
    tick();
    check("to_err_clear", f_err, 0);

    // ACK on the 8th ACCESS cycle
    fetch_req = 1; mem_rdata = 32'hABCD_0123;
    repeat (8) tick();
    check("ack8_rd", m_rd, 1);
    check("ack8_not_done", f_done, 0);
    mem_ack = 1;
    tick();
    check("ack8_done", f_done, 1);
    check("ack8_err", f_err, 0);
    check("ack8_data", f_data, 32'hABCD_0123);
    fetch_req = 0; mem_ack = 0;
    tick();

    // Reset in the 3rd ACCESS cycle
    data_req = 1; data_we = 0; data_addr = 32'h850; mem_rdata = 32'h7777_8888;
    repeat (3) tick();
    check("rst3_busy_before", busy, 1);
    rst = 1;
    tick();
    rst = 0;
    check("rst3_idle", busy, 0);
    check("rst3_rd", m_rd, 0);
    check("rst3_ddone", d_done, 0);
    check("rst3_ddata", d_data, 0);
    tick();
    check("rst3_regrant_rd", m_rd, 1);
    check("rst3_regrant_addr", m_addr, 32'h850);
    check("rst3_regrant_lg", last_grant, 1);
    mem_ack = 1;
    tick();
    check("rst3_regrant_done", d_done, 1);
    check("rst3_regrant_data", d_data, 32'h7777_8888);
    data_req = 0; mem_ack = 0;
    tick();

    // USE_ACK=0 instance completes without ACK
    do_reset();
    fetch_req = 1; fetch_addr = 32'h860; mem_rdata = 32'h5A5A_5A5A; mem_ack = 0;
    tick();
    check("na_rd", m_rd2, 1);
    check("na_addr", m_addr2, 32'h860);
    tick();
    check("na_done", f_done2, 1);
    check("na_err", f_err2, 0);
    check("na_data", f_data2, 32'h5A5A_5A5A);
    fetch_req = 0;
    tick();
    check("na_idle", busy2, 0);
    data_req = 1; data_we = 1; data_addr = 32'h870; data_wdata = 32'h0BAD_F00D;
    tick();
    check("na_wr", m_wr2, 1);
    check("na_wdata", m_wdata2, 32'h0BAD_F00D);
    tick();
    check("na_ddone", d_done2, 1);
    check("na_derr", d_err2, 0);
    data_req = 0; data_we = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATAWIDTH_BUS, 32, width of address and data buses.
- TIMEOUT_CYCLES, 8, maximum ACCESS cycles without ACK (1..15).
- USE_ACK, 1, 1 = wait for MEM_ACK; 0 = complete every access after one ACCESS cycle.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- MEMORY_ARBITER_CLOCK_50  in  1  single clock; all state on its rising edge.
- MEMORY_ARBITER_RESET_InHigh  in  1  synchronous, active-high reset.
- FETCH_REQ  in  1  instruction-fetch read request.
- FETCH_ADDRESS  in  DATAWIDTH_BUS  fetch address.
- FETCH_DATA_OutBUS  out  DATAWIDTH_BUS  fetch read data (registered).
- FETCH_DONE  out  1  fetch completion pulse.
- FETCH_ERR  out  1  fetch timed out; valid with FETCH_DONE.
- DATA_REQ  in  1  load/store request.
- DATA_WE  in  1  1 = write, 0 = read.
- DATA_ADDRESS  in  DATAWIDTH_BUS  data address.
- DATA_WDATA  in  DATAWIDTH_BUS  store data.
- DATA_DATA_OutBUS  out  DATAWIDTH_BUS  load data (registered).
- DATA_DONE  out  1  data completion pulse.
- DATA_ERR  out  1  data access timed out; valid with DATA_DONE.
- MEM_RD  out  1  main-memory read strobe.
- MEM_WR  out  1  main-memory write strobe.
- MEM_ADDRESS  out  DATAWIDTH_BUS  main-memory address.
- MEM_WDATA  out  DATAWIDTH_BUS  main-memory write data.
- MEM_RDATA  in  DATAWIDTH_BUS  main-memory read data.
- MEM_ACK  in  1  main-memory acknowledge.
- BUSY  out  1  high in any state other than IDLE.
- LAST_GRANT  out  1  0 = fetch granted last, 1 = data granted last.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.

REQ-004 In IDLE, if either REQ is high, the FSM SHALL go to ACCESS at the next edge and latch the following: owner, address, WE (fetch is always read) and WDATA.

REQ-005 Arbitration SHALL work as follows:
- Only one REQ high: grant that requester.
- Both high: grant the requester not indicated by LAST_GRANT (round-robin).
- LAST_GRANT SHALL update on entry to ACCESS.

REQ-006 During ACCESS, the memory strobes SHALL behave as follows:
- MEM_RD = NOT latched WE; MEM_WR = latched WE.
- MEM_ADDRESS and MEM_WDATA are driven from the latched values.
- Outside ACCESS: MEM_RD = MEM_WR = 0, and MEM_ADDRESS/MEM_WDATA hold their last values.

REQ-007 With USE_ACK=1, an ACCESS cycle with MEM_ACK=1 SHALL go to DONE, capturing MEM_RDATA into the owner's data register on reads (writes leave it unchanged), with ERR=0.

REQ-008 A 4-bit ACCESS cycle counter SHALL clear on entering ACCESS.
- If the TIMEOUT_CYCLES-th ACCESS cycle has MEM_ACK=0: go to DONE with owner ERR=1 and owner data register = 0.
- MEM_ACK=1 in that same cycle: ACK wins, ERR=0.

REQ-009 With USE_ACK=0, MEM_ACK SHALL be ignored, and the first ACCESS cycle SHALL complete as if MEM_ACK=1.

REQ-010 In DONE:
- The owner's DONE SHALL be high for exactly that one cycle and ERR valid alongside it; the non-owner's DONE and ERR SHALL stay 0.
- The next state SHALL be IDLE unconditionally.
- ERR SHALL clear when DONE falls.

REQ-011 Minimum latency: REQ high in IDLE at cycle 0 -> strobe in cycle 1 -> DONE in cycle 2 (with ACK in cycle 1) -> IDLE in cycle 3.

REQ-012 The requester handshake SHALL be:
- Requesters hold REQ and operands stable until their DONE, and drop REQ the cycle after DONE.
- REQ still high in the IDLE cycle after DONE SHALL be treated as a new request.
- REQ changes during ACCESS/DONE SHALL be ignored.

REQ-013 A requester deasserting REQ mid-ACCESS SHALL NOT abort the access; it still completes and pulses DONE.

REQ-014 FETCH_DATA_OutBUS and DATA_DATA_OutBUS SHALL hold their values until overwritten by their owner's next read completion or timeout.

Reset
REQ-015 On an edge with MEMORY_ARBITER_RESET_InHigh=1, the block SHALL set:
- state = IDLE, LAST_GRANT = 1 (fetch wins the first tie), counter = 0.
- MEM_RD = MEM_WR = 0 and MEM_ADDRESS = MEM_WDATA = 0.
- All DONE/ERR = 0, both data outputs = 0, BUSY = 0.

REQ-016 Reset SHALL take priority over every other input; it also applies mid-ACCESS or in DONE.
- The in-flight access is abandoned, with no DONE pulse.
- The first request after reset release SHALL be arbitrated normally.

Verification
REQ-017 Single fetch read: FETCH_REQ=1, FETCH_ADDRESS=0x800, MEM_RDATA=0xC4002000, MEM_ACK=1 in cycle 1 -> MEM_RD=1 in cycle 1 only; FETCH_DONE=1 in cycle 2 with FETCH_DATA_OutBUS=0xC4002000 and FETCH_ERR=0.

REQ-018 Tie after reset: FETCH_REQ and DATA_REQ both rise in the same cycle, with ACK immediate -> fetch is served first (DONE in cycle 2); data's strobe is in cycle 4 and DATA_DONE in cycle 5; LAST_GRANT reads 0 then 1.

REQ-019 Store: DATA_REQ=1, DATA_WE=1, DATA_ADDRESS=0x830, DATA_WDATA=0xFFFFFFFF -> MEM_WR=1 with MEM_ADDRESS=0x830 and MEM_WDATA=0xFFFFFFFF; MEM_RD=0 throughout; DATA_DATA_OutBUS unchanged.

REQ-020 Timeout: MEM_ACK tied 0 with TIMEOUT_CYCLES=8 -> MEM_RD high for exactly 8 cycles, then DONE=1 with ERR=1 and the data output = 0.

REQ-021 ACK arriving on the 8th ACCESS cycle -> ERR=0 and the data is captured.

REQ-022 Reset asserted in the 3rd ACCESS cycle -> the next cycle shows IDLE, MEM_RD=0 and no DONE ever issued; a fresh DATA_REQ is then granted normally.

REQ-023 USE_ACK=0 with MEM_ACK=0 -> every access completes in minimum latency with ERR=0.
